// File: rtl/i2c_passthru_bitrx.sv
// Single-bit receiver for one side of a pass-through I2C bus: conditions raw SCL/SDA,
// then records SDA at SCL rise, any SDA motion while SCL is high, and SDA at SCL fall.
module i2c_passthru_bitrx #(
  parameter int FILT_LEN              = 3,
  parameter int WIDTH_FILT            = 2,
  parameter int F_REF_T_TIMEOUT       = 63,
  parameter int WIDTH_F_REF_T_TIMEOUT = 6
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_f_ref,
  input  logic i_start_rx,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_filt,
  output logic o_sda_filt,
  output logic o_sda_init_valid,
  output logic o_sda_init,
  output logic o_sda_mid_change,
  output logic o_sda_final,
  output logic o_done,
  output logic o_timeout
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_LOW  = 3'd1;
  localparam logic [2:0] WAIT_RISE = 3'd2;
  localparam logic [2:0] HIGH      = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  localparam int NUM_LINES = 2;
  localparam int L_SCL     = 0;
  localparam int L_SDA     = 1;

  localparam logic [WIDTH_FILT-1:0] FILT_LAST =
    WIDTH_FILT'(FILT_LEN - 1);
  localparam logic [WIDTH_F_REF_T_TIMEOUT-1:0] TMO_MAX =
    WIDTH_F_REF_T_TIMEOUT'(F_REF_T_TIMEOUT);

  logic [NUM_LINES-1:0] raw;
  logic [NUM_LINES-1:0] filt;
  logic [NUM_LINES-1:0] filt_d;

  assign raw = {i_sda, i_scl};

  // Per-line synchronizer + run-length filter. Filtered lines reset high (idle bus).
  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    logic [1:0]            sync;
    logic [WIDTH_FILT-1:0] cnt;
    logic                  filt_q;
    logic                  filt_dq;

    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        sync    <= 2'b11;
        cnt     <= '0;
        filt_q  <= 1'b1;
        filt_dq <= 1'b1;
      end else begin
        sync    <= {sync[0], raw[g]};
        filt_dq <= filt_q;
        if (sync[1] == filt_q) begin
          cnt <= '0;
        end else if (cnt == FILT_LAST) begin
          filt_q <= sync[1];
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign filt[g]   = filt_q;
    assign filt_d[g] = filt_dq;
  end

  assign o_scl_filt = filt[L_SCL];
  assign o_sda_filt = filt[L_SDA];

  logic scl_rise, scl_fall, scl_edge, sda_chg;
  assign scl_rise = filt[L_SCL] & ~filt_d[L_SCL];
  assign scl_fall = ~filt[L_SCL] & filt_d[L_SCL];
  assign scl_edge = scl_rise | scl_fall;
  assign sda_chg  = filt[L_SDA] ^ filt_d[L_SDA];

  logic f_ref_d, f_ref_tick;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) f_ref_d <= 1'b0;
    else         f_ref_d <= i_f_ref;
  end
  assign f_ref_tick = i_f_ref & ~f_ref_d;

  logic [2:0]                       state;
  logic [WIDTH_F_REF_T_TIMEOUT-1:0] tmo_cnt;
  logic [WIDTH_F_REF_T_TIMEOUT-1:0] tmo_cnt_nxt;
  logic                             tmo_hit;

  // Ticks since the bit last made progress; saturates so it can never wrap.
  always_comb begin
    tmo_cnt_nxt = tmo_cnt;
    if (scl_edge)
      tmo_cnt_nxt = '0;
    else if (f_ref_tick && (tmo_cnt != TMO_MAX))
      tmo_cnt_nxt = tmo_cnt + 1'b1;
  end
  assign tmo_hit = !scl_edge && f_ref_tick && (tmo_cnt_nxt == TMO_MAX);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state            <= IDLE;
      tmo_cnt          <= '0;
      o_sda_init_valid <= 1'b0;
      o_sda_init       <= 1'b0;
      o_sda_mid_change <= 1'b0;
      o_sda_final      <= 1'b0;
      o_done           <= 1'b0;
      o_timeout        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // Edges arriving with the start are deliberately dropped; the
          // entry state is chosen from the current filtered SCL level.
          if (i_start_rx) begin
            o_sda_init_valid <= 1'b0;
            o_sda_init       <= 1'b0;
            o_sda_mid_change <= 1'b0;
            o_sda_final      <= 1'b0;
            o_done           <= 1'b0;
            o_timeout        <= 1'b0;
            tmo_cnt          <= '0;
            state            <= o_scl_filt ? WAIT_LOW : WAIT_RISE;
          end
        end
        WAIT_LOW, WAIT_RISE, HIGH: begin
          tmo_cnt <= tmo_cnt_nxt;
          if (state == WAIT_LOW && scl_fall)
            state <= WAIT_RISE;
          if (state == WAIT_RISE && scl_rise) begin
            o_sda_init       <= o_sda_filt;
            o_sda_init_valid <= 1'b1;
            state            <= HIGH;
          end
          if (state == HIGH) begin
            if (sda_chg)
              o_sda_mid_change <= 1'b1;
            if (scl_fall) begin
              o_sda_final <= o_sda_filt;
              o_done      <= 1'b1;
              state       <= DONE;
            end
          end
          if (tmo_hit) begin
            o_timeout <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
